// File: rtl/spi_master_arb_pkg.sv
// Shared definitions for the SPI master arbiter: FSM state codes, op encoding
// and the transaction descriptor handed to the SPI controller.
package spi_master_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_BUSY  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_QRD = 2'd2;
  localparam logic [1:0] OP_QWR = 2'd3;

  typedef struct packed {
    logic [31:0] cmd;
    logic [5:0]  cmd_len;
    logic [31:0] addr;
    logic [5:0]  addr_len;
    logic [15:0] data_len;
    logic [3:0]  csreg;
  } desc_t;

  // Strobe vector bit order is {qwr, qrd, wr, rd}, so the op code is the bit index.
  function automatic logic [3:0] op_strobe(input logic [1:0] op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/spi_master_arb_rr.sv
// Round-robin picker: one-hot grant for the first asserted request at or
// after i_ptr, wrapping around; o_valid low when nothing is requested.
module spi_master_arb_rr
  import spi_master_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_valid
);

  // Requester i is the k-th candidate after the pointer when ptr == (i-k) mod N.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!o_valid && i_req[i] && (i_ptr == PTR_W'((i - k + N_REQ) % N_REQ))) begin
          o_gnt[i] = 1'b1;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin arbiter sharing one SPI controller between N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add the BUSY watchdog (spi_swrst / tout_o).
module spi_master_arb
  import spi_master_arb_pkg::*;
#(
  parameter int          N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*32-1:0]   req_cmd_i,
  input  logic [N_REQ*6-1:0]    req_cmd_len_i,
  input  logic [N_REQ*32-1:0]   req_addr_i,
  input  logic [N_REQ*6-1:0]    req_addr_len_i,
  input  logic [N_REQ*16-1:0]   req_data_len_i,
  input  logic [N_REQ*4-1:0]    req_csreg_i,
  input  logic [N_REQ*2-1:0]    req_op_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [N_REQ-1:0]      tout_o,
  output logic [31:0]           spi_cmd,
  output logic [5:0]            spi_cmd_len,
  output logic [31:0]           spi_addr,
  output logic [5:0]            spi_addr_len,
  output logic [15:0]           spi_data_len,
  output logic [3:0]            spi_csreg,
  output logic                  spi_rd,
  output logic                  spi_wr,
  output logic                  spi_qrd,
  output logic                  spi_qwr,
  output logic                  spi_swrst,
  output logic [15:0]           spi_dummy_rd,
  output logic [15:0]           spi_dummy_wr,
  input  logic                  eot_i,
  input  logic [N_REQ*32-1:0]   tx_data_i,
  input  logic [N_REQ-1:0]      tx_valid_i,
  output logic [N_REQ-1:0]      tx_ready_o,
  output logic [31:0]           rx_data_o,
  output logic [N_REQ-1:0]      rx_valid_o,
  input  logic [N_REQ-1:0]      rx_ready_i,
  output logic [31:0]           spi_data_tx,
  output logic                  spi_data_tx_valid,
  input  logic                  spi_data_tx_ready,
  input  logic [31:0]           spi_data_rx,
  input  logic                  spi_data_rx_valid,
  output logic                  spi_data_rx_ready
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  logic [PTR_W-1:0] r_win;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [3:0]       r_strb;
  desc_t            r_desc;

  logic [N_REQ-1:0] w_pick_gnt;
  logic             w_pick_valid;
  logic [PTR_W-1:0] w_pick_idx;
  logic [PTR_W-1:0] w_ptr_next;
  desc_t            w_desc;
  logic [1:0]       w_op;
  logic             w_tmo;

  spi_master_arb_rr #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (req_i),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_gnt[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_desc = '0;
    w_op   = OP_RD;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_win == PTR_W'(i)) begin
        w_desc.cmd      = req_cmd_i[i*32 +: 32];
        w_desc.cmd_len  = req_cmd_len_i[i*6 +: 6];
        w_desc.addr     = req_addr_i[i*32 +: 32];
        w_desc.addr_len = req_addr_len_i[i*6 +: 6];
        w_desc.data_len = req_data_len_i[i*16 +: 16];
        w_desc.csreg    = req_csreg_i[i*4 +: 4];
        w_op            = req_op_i[i*2 +: 2];
      end
    end
  end

  assign w_ptr_next = (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + PTR_W'(1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= ST_IDLE;
      r_win    <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_strb   <= '0;
      r_desc   <= '0;
    end else begin
      r_done <= '0;
      r_strb <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_win   <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_desc  <= w_desc;
          r_strb  <= op_strobe(w_op);
          r_state <= ST_START;
        end
        ST_START: r_state <= ST_BUSY;
        ST_BUSY: begin
          // A watchdog expiry closes the transaction like eot_i but without done_o.
          if (eot_i || w_tmo) begin
            if (eot_i) r_done <= r_gnt;
            r_gnt    <= '0;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0]      r_wdog;
  logic [N_REQ-1:0] r_tout;
  logic             r_swrst;

  // Down-counter loaded as BUSY is entered; terminal count lands the pulse
  // TIMEOUT_CYCLES cycles after the strobe.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wdog  <= '0;
      r_tout  <= '0;
      r_swrst <= 1'b0;
    end else begin
      r_tout  <= '0;
      r_swrst <= 1'b0;
      if (r_state == ST_START) r_wdog <= 32'(TIMEOUT_CYCLES - 1);
      else if (r_state == ST_BUSY && r_wdog != '0) r_wdog <= r_wdog - 32'd1;
      if (w_tmo) begin
        r_tout  <= r_gnt;
        r_swrst <= 1'b1;
      end
    end
  end

  assign w_tmo     = (r_state == ST_BUSY) && !eot_i && (r_wdog <= 32'd1);
  assign tout_o    = r_tout;
  assign spi_swrst = r_swrst;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo        = 1'b0;
  assign tout_o       = '0;
  assign spi_swrst    = 1'b0;
`endif

  assign gnt_o  = r_gnt;
  assign done_o = r_done;
  assign {spi_qwr, spi_qrd, spi_wr, spi_rd} = r_strb;

  assign spi_cmd      = r_desc.cmd;
  assign spi_cmd_len  = r_desc.cmd_len;
  assign spi_addr     = r_desc.addr;
  assign spi_addr_len = r_desc.addr_len;
  assign spi_data_len = r_desc.data_len;
  assign spi_csreg    = r_desc.csreg;
  assign spi_dummy_rd = 16'h0000;
  assign spi_dummy_wr = 16'h0000;

  always_comb begin
    spi_data_tx       = '0;
    spi_data_tx_valid = 1'b0;
    spi_data_rx_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) begin
        spi_data_tx       = tx_data_i[i*32 +: 32];
        spi_data_tx_valid = tx_valid_i[i];
        spi_data_rx_ready = rx_ready_i[i];
      end
    end
  end

  assign tx_ready_o = r_gnt & {N_REQ{spi_data_tx_ready}};
  assign rx_valid_o = r_gnt & {N_REQ{spi_data_rx_valid}};
  assign rx_data_o  = spi_data_rx;

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb: directed transactions push expected
// strobes/done/timeout pulses; a negedge monitor pops and compares them.
module tb_spi_master_arb;

  localparam int N = 2;
  localparam int T = 16;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N*32-1:0] req_cmd_i = '0;
  logic [N*6-1:0]  req_cmd_len_i = '0;
  logic [N*32-1:0] req_addr_i = '0;
  logic [N*6-1:0]  req_addr_len_i = '0;
  logic [N*16-1:0] req_data_len_i = '0;
  logic [N*4-1:0]  req_csreg_i = '0;
  logic [N*2-1:0]  req_op_i = '0;
  logic [N-1:0]    gnt_o, done_o, tout_o;
  logic [31:0]     spi_cmd, spi_addr;
  logic [5:0]      spi_cmd_len, spi_addr_len;
  logic [15:0]     spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [3:0]      spi_csreg;
  logic            spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
  logic            eot_i = 1'b0;
  logic [N*32-1:0] tx_data_i = '0;
  logic [N-1:0]    tx_valid_i = '0;
  logic [N-1:0]    tx_ready_o;
  logic [31:0]     rx_data_o;
  logic [N-1:0]    rx_valid_o;
  logic [N-1:0]    rx_ready_i = '0;
  logic [31:0]     spi_data_tx;
  logic            spi_data_tx_valid;
  logic            spi_data_tx_ready = 1'b0;
  logic [31:0]     spi_data_rx = '0;
  logic            spi_data_rx_valid = 1'b0;
  logic            spi_data_rx_ready;

  spi_master_arb #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i),
    .req_cmd_i(req_cmd_i), .req_cmd_len_i(req_cmd_len_i),
    .req_addr_i(req_addr_i), .req_addr_len_i(req_addr_len_i),
    .req_data_len_i(req_data_len_i), .req_csreg_i(req_csreg_i), .req_op_i(req_op_i),
    .gnt_o(gnt_o), .done_o(done_o), .tout_o(tout_o),
    .spi_cmd(spi_cmd), .spi_cmd_len(spi_cmd_len), .spi_addr(spi_addr),
    .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len), .spi_csreg(spi_csreg),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr),
    .spi_swrst(spi_swrst), .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
    .eot_i(eot_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
    .spi_data_tx_ready(spi_data_tx_ready), .spi_data_rx(spi_data_rx),
    .spi_data_rx_valid(spi_data_rx_valid), .spi_data_rx_ready(spi_data_rx_ready)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   strb;
    logic [31:0]  cmd;
    logic [N-1:0] gnt;
    logic [15:0]  dlen;
    int           cyc;
  } strb_exp_t;

  typedef struct {
    logic [N-1:0] who;
    int           cyc;
  } pulse_exp_t;

  strb_exp_t  q_strb[$];
  pulse_exp_t q_done[$];
  pulse_exp_t q_tout[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge HCLK) begin : monitor
    strb_exp_t  e;
    pulse_exp_t p;
    logic [3:0] s;
    if (mon_en && !HRESET) begin
      chk("gnt_onehot0", 64'($onehot0(gnt_o)), 64'd1);
      s = {spi_qwr, spi_qrd, spi_wr, spi_rd};
      if (s != 4'b0) begin
        if (q_strb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got %b expected none", s);
        end else begin
          e = q_strb.pop_front();
          chk("strobe", 64'(s), 64'(e.strb));
          chk("spi_cmd", 64'(spi_cmd), 64'(e.cmd));
          chk("strobe_gnt", 64'(gnt_o), 64'(e.gnt));
          chk("spi_data_len", 64'(spi_data_len), 64'(e.dlen));
          if (e.cyc >= 0) chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (done_o != '0) begin
        if (q_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b expected none", done_o);
        end else begin
          p = q_done.pop_front();
          chk("done_o", 64'(done_o), 64'(p.who));
          chk("done_cycle", 64'(cyc), 64'(p.cyc));
        end
      end
      if (tout_o != '0 || spi_swrst) begin
        if (q_tout.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tout: got tout=%b swrst=%b expected none", tout_o, spi_swrst);
        end else begin
          p = q_tout.pop_front();
          chk("tout_o", 64'(tout_o), 64'(p.who));
          chk("spi_swrst", 64'(spi_swrst), 64'd1);
          chk("tout_cycle", 64'(cyc), 64'(p.cyc));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] cmd,
                         input logic [15:0] dlen);
    req_op_i[r*2 +: 2]         = op;
    req_cmd_i[r*32 +: 32]      = cmd;
    req_data_len_i[r*16 +: 16] = dlen;
    req_cmd_len_i[r*6 +: 6]    = 6'd8;
    req_addr_i[r*32 +: 32]     = 32'h1000 + 32'(r);
    req_addr_len_i[r*6 +: 6]   = 6'd24;
    req_csreg_i[r*4 +: 4]      = 4'(r + 1);
  endtask

  task automatic push_strb(input logic [N-1:0] who, input logic [3:0] strb,
                           input logic [31:0] cmd, input logic [15:0] dlen, input int c);
    strb_exp_t e;
    e.strb = strb; e.cmd = cmd; e.gnt = who; e.dlen = dlen; e.cyc = c;
    q_strb.push_back(e);
  endtask

  task automatic wait_strobe(output int sc);
    sc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if ({spi_qwr, spi_qrd, spi_wr, spi_rd} != 4'b0) begin
        sc = cyc;
        break;
      end
    end
    if (sc < 0) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: no strobe within 40 cycles, expected one");
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (done_o != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done_o within 40 cycles, expected one");
    end
  endtask

  // Called at a negedge: eot_i is sampled at the next rising edge.
  task automatic pulse_eot(input logic [N-1:0] who, output int ec);
    pulse_exp_t p;
    eot_i = 1'b1;
    ec = cyc;
    p.who = who; p.cyc = cyc + 1;
    q_done.push_back(p);
    @(posedge HCLK);
    #1 eot_i = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int sc, ec;
    logic [N-1:0] who;
    #2 HRESET = 1'b1;
    idle(2);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_tout", 64'(tout_o), 64'd0);
    chk("rst_strobes", 64'({spi_qwr, spi_qrd, spi_wr, spi_rd, spi_swrst}), 64'd0);
    chk("rst_cmd", 64'(spi_cmd), 64'd0);
    chk("rst_addr", 64'(spi_addr), 64'd0);
    chk("rst_data_len", 64'(spi_data_len), 64'd0);
    chk("rst_dummy", 64'({spi_dummy_rd, spi_dummy_wr}), 64'd0);
    chk("rst_tx_valid", 64'(spi_data_tx_valid), 64'd0);
    HRESET = 1'b0;
    mon_en = 1'b1;

    // eot_i while idle must be ignored
    idle(2);
    eot_i = 1'b1;
    idle(1);
    eot_i = 1'b0;
    idle(3);
    chk("idle_eot_gnt", 64'(gnt_o), 64'd0);

    // single write from requester 0, cmd 0x9F
    set_req(0, 2'd1, 32'h9F, 16'd32);
    push_strb(2'b01, 4'b0010, 32'h9F, 16'd32, cyc + 2);
    req_i = 2'b01;
    wait_strobe(sc);
    idle(2);
    pulse_eot(2'b01, ec);
    wait_done();
    req_i = 2'b00;
    idle(2);
    chk("desc_hold_cmd", 64'(spi_cmd), 64'h9F);

    // requester 1 owns the data path; drops req mid-transaction
    set_req(1, 2'd3, 32'hEB, 16'd4);
    push_strb(2'b10, 4'b1000, 32'hEB, 16'd4, cyc + 2);
    req_i = 2'b10;
    wait_strobe(sc);
    tx_data_i         = {32'hDEADBEEF, 32'h12345678};
    tx_valid_i        = 2'b11;
    spi_data_tx_ready = 1'b1;
    spi_data_rx       = 32'hCAFEF00D;
    spi_data_rx_valid = 1'b1;
    rx_ready_i        = 2'b01;
    #1;
    chk("spi_data_tx", 64'(spi_data_tx), 64'hDEADBEEF);
    chk("spi_data_tx_valid", 64'(spi_data_tx_valid), 64'd1);
    chk("tx_ready_o", 64'(tx_ready_o), 64'b10);
    chk("rx_valid_o", 64'(rx_valid_o), 64'b10);
    chk("rx_data_o", 64'(rx_data_o), 64'hCAFEF00D);
    chk("rx_ready_owner_low", 64'(spi_data_rx_ready), 64'd0);
    rx_ready_i = 2'b10;
    #1;
    chk("rx_ready_owner_high", 64'(spi_data_rx_ready), 64'd1);
    req_i = 2'b00;
    idle(2);
    pulse_eot(2'b10, ec);
    wait_done();
    #1;
    chk("noown_tx_valid", 64'(spi_data_tx_valid), 64'd0);
    chk("noown_rx_ready", 64'(spi_data_rx_ready), 64'd0);
    chk("noown_tx_ready", 64'(tx_ready_o), 64'd0);
    chk("noown_rx_valid", 64'(rx_valid_o), 64'd0);
    tx_valid_i = '0; spi_data_tx_ready = 1'b0; spi_data_rx_valid = 1'b0; rx_ready_i = '0;

    // both requesting and held: order 0,1,0,1 with 4-cycle eot-to-strobe gap
    idle(2);
    set_req(0, 2'd0, 32'h11, 16'd8);
    set_req(1, 2'd2, 32'h22, 16'd16);
    push_strb(2'b01, 4'b0001, 32'h11, 16'd8, cyc + 2);
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      who = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_strobe(sc);
      idle(1);
      pulse_eot(who, ec);
      if (k < 3) begin
        if (who == 2'b01) push_strb(2'b10, 4'b0100, 32'h22, 16'd16, ec + 4);
        else              push_strb(2'b01, 4'b0001, 32'h11, 16'd8, ec + 4);
      end
      wait_done();
    end
    req_i = 2'b00;

    // no eot_i for a long BUSY
    idle(2);
    set_req(0, 2'd0, 32'h33, 16'd2);
    push_strb(2'b01, 4'b0001, 32'h33, 16'd2, cyc + 2);
    req_i = 2'b01;
    wait_strobe(sc);
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      pulse_exp_t p;
      bit seen = 1'b0;
      p.who = 2'b01; p.cyc = sc + T;
      q_tout.push_back(p);
      for (int i = 0; i < 40; i++) begin
        @(negedge HCLK);
        if (tout_o != '0) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL tout_timeout: no tout_o within 40 cycles, expected one");
      end
      req_i = 2'b00;
      idle(3);
      chk("after_tout_gnt", 64'(gnt_o), 64'd0);
    end
`else
    idle(40);
    chk("busy_hold_gnt", 64'(gnt_o), 64'b01);
    pulse_eot(2'b01, ec);
    wait_done();
    req_i = 2'b00;
`endif

    // reset in BUSY: immediate clear, pointer back to 0
    idle(2);
    set_req(0, 2'd1, 32'h44, 16'd1);
    push_strb(2'b01, 4'b0010, 32'h44, 16'd1, cyc + 2);
    req_i = 2'b01;
    spi_data_tx_ready = 1'b1;
    wait_strobe(sc);
    idle(1);
    #2 HRESET = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    chk("mid_rst_tout", 64'(tout_o), 64'd0);
    chk("mid_rst_strobes", 64'({spi_qwr, spi_qrd, spi_wr, spi_rd, spi_swrst}), 64'd0);
    chk("mid_rst_cmd", 64'(spi_cmd), 64'd0);
    chk("mid_rst_data_len", 64'(spi_data_len), 64'd0);
    chk("mid_rst_tx_ready", 64'(tx_ready_o), 64'd0);
    idle(1);
    req_i = 2'b00;
    spi_data_tx_ready = 1'b0;
    HRESET = 1'b0;
    idle(2);
    set_req(0, 2'd2, 32'h55, 16'd3);
    set_req(1, 2'd1, 32'h66, 16'd5);
    push_strb(2'b01, 4'b0100, 32'h55, 16'd3, cyc + 2);
    req_i = 2'b11;
    wait_strobe(sc);
    idle(1);
    pulse_eot(2'b01, ec);
    push_strb(2'b10, 4'b0010, 32'h66, 16'd5, ec + 4);
    wait_done();
    req_i = 2'b10;
    wait_strobe(sc);
    idle(1);
    pulse_eot(2'b10, ec);
    wait_done();
    req_i = 2'b00;

    idle(4);
    chk("q_strb_empty", 64'(q_strb.size()), 64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);
    chk("q_tout_empty", 64'(q_tout.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
